// File: rtl/sa_array_seq.sv
// Tile sequencer for the systolic array: feed K steps, walk the context
// switch across columns, let it settle through the rows, then drain.
module sa_array_seq #(
    parameter int X = 3,
    parameter int Y = 3,
    parameter int PE_LAT = 3,
    parameter int K_W = 16,
    localparam int COL_W = (X > 1) ? $clog2(X) : 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [K_W-1:0]   i_cmd_k,
    input  logic             i_cmd_clear,
    input  logic             i_abort,
    output logic             o_feed_req,
    input  logic             i_feed_valid,
    output logic             o_feed_zero,
    output logic             o_pipeline_en,
    output logic [X-1:0]     o_cswitch_arr,
    output logic             o_reg_clear,
    output logic             o_cscan_en,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [COL_W-1:0] o_out_col,
    output logic             o_busy,
    output logic             o_done
);

    localparam int SETTLE_N = Y - 1 + PE_LAT;
    localparam int ST_LAST = (SETTLE_N > 0) ? SETTLE_N - 1 : 0;
    localparam int PH_MAX = (X > SETTLE_N) ? X : SETTLE_N;
    localparam int PH_W = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_SWITCH,
        S_SETTLE,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q;
    logic [K_W:0]     step_q;
    logic [PH_W-1:0]  ph_q;
    logic [COL_W-1:0] col_q;
    logic             done_q;

    logic accept, feed_last, sw_last, st_last, beat, beat_last;

    assign accept    = (state_q == S_IDLE) && i_cmd_valid && !i_abort;
    assign feed_last = (state_q == S_FEED) && i_feed_valid
                       && (step_q == {1'b0, k_q});
    assign sw_last   = (ph_q == PH_W'(X - 1));
    assign st_last   = (ph_q == PH_W'(ST_LAST));
    assign beat      = (state_q == S_DRAIN) && i_out_ready;
    assign beat_last = beat && (col_q == COL_W'(X - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_FEED;
            S_FEED:   if (feed_last) state_d = S_SWITCH;
            S_SWITCH: begin
                if (sw_last) begin
                    if (SETTLE_N == 0) state_d = S_DRAIN;
                    else state_d = S_SETTLE;
                end
            end
            S_SETTLE: if (st_last) state_d = S_DRAIN;
            S_DRAIN:  if (beat_last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (i_abort) state_d = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters restart whenever the phase changes, including on abort.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            k_q    <= '0;
            step_q <= '0;
            ph_q   <= '0;
            col_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (accept) k_q <= i_cmd_k;

            if (state_d != S_FEED) step_q <= '0;
            else if ((state_q == S_FEED) && i_feed_valid)
                step_q <= step_q + 1'b1;

            if (state_d != state_q) ph_q <= '0;
            else if ((state_q == S_SWITCH) || (state_q == S_SETTLE))
                ph_q <= ph_q + 1'b1;

            if (state_d != S_DRAIN) col_q <= '0;
            else if (beat) col_q <= col_q + 1'b1;

            done_q <= beat_last && !i_abort;
        end
    end

    always_comb begin
        o_cswitch_arr = '0;
        if (state_q == S_SWITCH) begin
            for (int i = 0; i < X; i++)
                o_cswitch_arr[i] = (ph_q == PH_W'(i));
        end
    end

    assign o_cmd_ready   = (state_q == S_IDLE) && !i_abort;
    assign o_reg_clear   = accept && i_cmd_clear;
    assign o_feed_req    = (state_q == S_FEED);
    assign o_feed_zero   = (state_q == S_SWITCH) || (state_q == S_SETTLE);
    assign o_pipeline_en = (state_q == S_FEED) ? i_feed_valid : o_feed_zero;
    assign o_out_valid   = (state_q == S_DRAIN);
    assign o_cscan_en    = beat;
    assign o_out_col     = col_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;

endmodule

// File: tb/tb_sa_array_seq.sv
// Randomized and directed checks of sa_array_seq against a cycle-level
// schedule model derived from the phase lengths.
module tb_sa_array_seq;

    localparam int AX = 3;
    localparam int AY = 3;
    localparam int AL = 3;
    localparam int AS = AY - 1 + AL;
    localparam int BX = 1;
    localparam int BY = 1;
    localparam int BL = 0;
    localparam logic [13:0] IDLE_V = 14'b10_0000_0000_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        a_cmd_valid = 0, a_cmd_ready, a_cmd_clear = 0, a_abort = 0;
    logic [15:0] a_cmd_k = '0;
    logic        a_feed_req, a_feed_valid = 0, a_feed_zero, a_pipeline_en;
    logic [2:0]  a_cswitch;
    logic        a_reg_clear, a_cscan_en, a_out_valid, a_out_ready = 0;
    logic [1:0]  a_out_col;
    logic        a_busy, a_done;

    logic        b_cmd_valid = 0, b_cmd_ready, b_cmd_clear = 0, b_abort = 0;
    logic [3:0]  b_cmd_k = '0;
    logic        b_feed_req, b_feed_valid = 0, b_feed_zero, b_pipeline_en;
    logic [0:0]  b_cswitch;
    logic        b_reg_clear, b_cscan_en, b_out_valid, b_out_ready = 0;
    logic [0:0]  b_out_col;
    logic        b_busy, b_done;

    logic [13:0] a_obs;
    assign a_obs = {a_cmd_ready, a_reg_clear, a_feed_req, a_feed_zero,
                    a_pipeline_en, a_cswitch, a_cscan_en, a_out_valid,
                    a_out_col, a_busy, a_done};

    int n_tests = 0;
    int n_fail = 0;
    int a_shifts = 0;
    bit pend_done = 0;

    sa_array_seq #(.X(AX), .Y(AY), .PE_LAT(AL), .K_W(16)) dut_a (
        .i_clk(clk), .i_rstn(rstn),
        .i_cmd_valid(a_cmd_valid), .o_cmd_ready(a_cmd_ready),
        .i_cmd_k(a_cmd_k), .i_cmd_clear(a_cmd_clear), .i_abort(a_abort),
        .o_feed_req(a_feed_req), .i_feed_valid(a_feed_valid),
        .o_feed_zero(a_feed_zero), .o_pipeline_en(a_pipeline_en),
        .o_cswitch_arr(a_cswitch), .o_reg_clear(a_reg_clear),
        .o_cscan_en(a_cscan_en), .o_out_valid(a_out_valid),
        .i_out_ready(a_out_ready), .o_out_col(a_out_col),
        .o_busy(a_busy), .o_done(a_done)
    );

    sa_array_seq #(.X(BX), .Y(BY), .PE_LAT(BL), .K_W(4)) dut_b (
        .i_clk(clk), .i_rstn(rstn),
        .i_cmd_valid(b_cmd_valid), .o_cmd_ready(b_cmd_ready),
        .i_cmd_k(b_cmd_k), .i_cmd_clear(b_cmd_clear), .i_abort(b_abort),
        .o_feed_req(b_feed_req), .i_feed_valid(b_feed_valid),
        .o_feed_zero(b_feed_zero), .o_pipeline_en(b_pipeline_en),
        .o_cswitch_arr(b_cswitch), .o_reg_clear(b_reg_clear),
        .o_cscan_en(b_cscan_en), .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready), .o_out_col(b_out_col),
        .o_busy(b_busy), .o_done(b_done)
    );

    // One tile on dut_a; cycle 0 is the accept cycle. With hold set the
    // next command stays valid and the done cycle becomes the next cycle 0.
    task automatic run_tile(input int k, input bit clr,
                            input int stall_pct, input int bp_pct,
                            input logic [63:0] stall_m,
                            input logic [63:0] bp_m,
                            input bit hold, input int nk, input bit nclr,
                            output int done_cyc);
        int fed, t1, beats, kk;
        bit fv, rdy;
        logic e_rdy, e_clr, e_freq, e_fz, e_pe, e_cs, e_ov, e_busy, e_done;
        logic [2:0] e_sw;
        logic [1:0] e_col;
        logic [13:0] exp_v;
        kk = k + 1;
        fed = 0;
        t1 = -1;
        beats = 0;
        done_cyc = -1;
        a_shifts = 0;
        for (int c = 0; c < 4000; c++) begin
            fv = !(c < 64 && stall_m[c]) && ($urandom_range(99) >= stall_pct);
            rdy = !(c < 64 && bp_m[c]) && ($urandom_range(99) >= bp_pct);
            a_feed_valid = fv;
            a_out_ready = rdy;
            if (c == 0) begin
                a_cmd_valid = 1;
                a_cmd_k = 16'(k);
                a_cmd_clear = clr;
            end else if (c == 1) begin
                a_cmd_valid = hold;
                a_cmd_k = 16'(nk);
                a_cmd_clear = nclr;
            end
            {e_rdy, e_clr, e_freq, e_fz, e_pe, e_cs, e_ov, e_done} = '0;
            e_sw = '0;
            e_col = '0;
            e_busy = 1;
            if (c == 0) begin
                e_rdy = 1;
                e_clr = clr;
                e_busy = 0;
                e_done = pend_done;
            end else if (fed < kk) begin
                e_freq = 1;
                e_pe = fv;
                if (fv) fed++;
                if (fed == kk) t1 = c + 1;
            end else if (c < t1 + AX) begin
                e_fz = 1;
                e_pe = 1;
                e_sw[c - t1] = 1'b1;
            end else if (c < t1 + AX + AS) begin
                e_fz = 1;
                e_pe = 1;
            end else begin
                e_ov = 1;
                e_col = 2'(beats);
                e_cs = rdy;
                if (rdy) beats++;
            end
            exp_v = {e_rdy, e_clr, e_freq, e_fz, e_pe, e_sw, e_cs, e_ov,
                     e_col, e_busy, e_done};
            @(negedge clk);
            n_tests++;
            if (a_obs !== exp_v) begin
                n_fail++;
                $display("FAIL tile cycle %0d: got %b required %b",
                         c, a_obs, exp_v);
            end
            if (a_cscan_en === 1'b1) a_shifts++;
            @(posedge clk);
            #1;
            if (beats == AX) begin
                done_cyc = c + 1;
                break;
            end
        end
        if (done_cyc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tile_timeout: got no done, required done");
        end else if (!hold) begin
            a_cmd_valid = 0;
            a_feed_valid = 0;
            a_out_ready = 0;
            @(negedge clk);
            n_tests++;
            if (a_obs !== (IDLE_V | 14'd1)) begin
                n_fail++;
                $display("FAIL tile_done cycle %0d: got %b required %b",
                         done_cyc, a_obs, IDLE_V | 14'd1);
            end
            @(posedge clk);
            #1;
            pend_done = 0;
        end else begin
            pend_done = 1;
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        #23;
        n_tests++;
        if (a_obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL reset_a: got %b required %b", a_obs, IDLE_V);
        end
        n_tests++;
        if ({b_cmd_ready, b_busy, b_done, b_cswitch} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_b: got %b required 1000",
                     {b_cmd_ready, b_busy, b_done, b_cswitch});
        end
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int d;
        run_tile(3, 1, 0, 0, '0, '0, 0, 0, 0, d);
        n_tests++;
        if (d !== 1 + 4 + AX + AS + AX) begin
            n_fail++;
            $display("FAIL basic_done: got %0d required %0d",
                     d, 1 + 4 + AX + AS + AX);
        end
    endtask

    task automatic test_feed_stall();
        int d;
        run_tile(3, 0, 0, 0, 64'hC, '0, 0, 0, 0, d);
        n_tests++;
        if (d !== 18) begin
            n_fail++;
            $display("FAIL stall_done: got %0d required 18", d);
        end
    endtask

    task automatic test_backpressure();
        int d;
        run_tile(3, 0, 0, 0, '0, 64'hC000, 0, 0, 0, d);
        n_tests++;
        if (d !== 18) begin
            n_fail++;
            $display("FAIL bp_done: got %0d required 18", d);
        end
        n_tests++;
        if (a_shifts !== AX) begin
            n_fail++;
            $display("FAIL bp_shifts: got %0d required %0d", a_shifts, AX);
        end
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 8; i++)
            run_tile($urandom_range(7), 1'($urandom), 30, 30, '0, '0,
                     0, 0, 0, d);
    endtask

    task automatic test_abort();
        for (int c = 0; c < 10; c++) begin
            a_cmd_valid = (c == 0);
            a_cmd_k = 16'd3;
            a_feed_valid = 1;
            a_out_ready = 1;
            a_abort = (c == 9);
            if (c == 9) begin
                @(negedge clk);
                n_tests++;
                if (a_feed_zero !== 1'b1 || a_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_pre: got fz=%b busy=%b required 1 1",
                             a_feed_zero, a_busy);
                end
            end
            @(posedge clk);
            #1;
        end
        a_abort = 0;
        for (int c = 10; c < 15; c++) begin
            @(negedge clk);
            n_tests++;
            if (a_obs !== IDLE_V) begin
                n_fail++;
                $display("FAIL abort_idle cycle %0d: got %b required %b",
                         c, a_obs, IDLE_V);
            end
            @(posedge clk);
            #1;
        end
        a_abort = 1;
        a_cmd_valid = 1;
        a_cmd_clear = 1;
        @(negedge clk);
        n_tests++;
        if ({a_cmd_ready, a_reg_clear} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_reject: got %b required 00",
                     {a_cmd_ready, a_reg_clear});
        end
        @(posedge clk);
        #1;
        a_abort = 0;
        a_cmd_valid = 0;
        a_cmd_clear = 0;
        @(negedge clk);
        n_tests++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reject_busy: got %b required 0", a_busy);
        end
        @(posedge clk);
        #1;
        pend_done = 0;
    endtask

    task automatic test_reset_mid();
        int d;
        for (int c = 0; c < 13; c++) begin
            a_cmd_valid = (c == 0);
            a_cmd_k = 16'd3;
            a_feed_valid = 1;
            a_out_ready = 1;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got out_valid=%b required 1", a_out_valid);
        end
        #1;
        rstn = 0;
        #1;
        n_tests++;
        if (a_obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL rst_async: got %b required %b", a_obs, IDLE_V);
        end
        @(posedge clk);
        #1;
        rstn = 1;
        a_out_ready = 0;
        a_feed_valid = 0;
        pend_done = 0;
        run_tile(3, 0, 0, 0, '0, '0, 0, 0, 0, d);
        n_tests++;
        if (d !== 16) begin
            n_fail++;
            $display("FAIL rst_clean_done: got %0d required 16", d);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        run_tile(2, 1, 0, 0, '0, '0, 1, 1, 0, d1);
        run_tile(1, 0, 0, 0, '0, '0, 0, 0, 0, d2);
        n_tests++;
        if (d1 !== 3 + 1 + AX + AS + AX) begin
            n_fail++;
            $display("FAIL b2b_done1: got %0d required %0d",
                     d1, 3 + 1 + AX + AS + AX);
        end
        n_tests++;
        if (d2 !== 2 + 1 + AX + AS + AX) begin
            n_fail++;
            $display("FAIL b2b_done2: got %0d required %0d",
                     d2, 2 + 1 + AX + AS + AX);
        end
    endtask

    task automatic test_boundary(input int k);
        int feeds, sw_c, done_c, exp_d;
        feeds = 0;
        sw_c = -1;
        done_c = -1;
        exp_d = 1 + (k + 1) + BX + (BY - 1 + BL) + BX;
        for (int c = 0; c < 100; c++) begin
            b_cmd_valid = (c == 0);
            b_cmd_k = 4'(k);
            b_feed_valid = 1;
            b_out_ready = 1;
            @(negedge clk);
            if (b_feed_req === 1'b1) feeds++;
            if (b_cswitch === 1'b1 && sw_c < 0) sw_c = c;
            if (b_done === 1'b1) done_c = c;
            @(posedge clk);
            #1;
            if (done_c >= 0) break;
        end
        b_cmd_valid = 0;
        n_tests++;
        if (done_c !== exp_d) begin
            n_fail++;
            $display("FAIL bnd_done k=%0d: got %0d required %0d",
                     k, done_c, exp_d);
        end
        n_tests++;
        if (feeds !== k + 1) begin
            n_fail++;
            $display("FAIL bnd_feeds k=%0d: got %0d required %0d",
                     k, feeds, k + 1);
        end
        n_tests++;
        if (sw_c !== k + 2) begin
            n_fail++;
            $display("FAIL bnd_switch k=%0d: got %0d required %0d",
                     k, sw_c, k + 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_feed_stall();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_boundary(0);
        test_boundary(15);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
